// File: rtl/act_bitplane_serializer.sv
// Bit-plane serializer: accepts M signed Pa-bit activations and presents them one
// bit-plane per cycle (LSB first) with accumulator write/shift/clear controls.
module act_bitplane_serializer #(
  parameter int M  = 16,
  parameter int Pa = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [M*Pa-1:0] in_act,
  output logic [M-1:0]    plane,
  output logic            plane_msb,
  output logic            w_en,
  output logic            s_en,
  output logic            cl_en,
  output logic            vec_done
);

  localparam int KW = (Pa > 1) ? $clog2(Pa) : 1;
  localparam logic [KW-1:0] KLAST = KW'(Pa - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state_q, state_d;
  logic [M*Pa-1:0]   act_q, act_d;
  logic [M*Pa-1:0]   hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              done_q, done_d;
  logic [KW-1:0]     k_q, k_d;
  logic              busy;
  logic              last;
  logic              accept;

  assign busy     = (state_q == STREAM);
  assign last     = busy && (k_q == KLAST);
  assign in_ready = !hold_full_q;
  assign accept   = in_valid && in_ready && en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      act_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      done_q      <= 1'b0;
      k_q         <= '0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      done_q      <= done_d;
      k_q         <= k_d;
    end
  end

  // Everything holds while en is low, including a pending vec_done pulse.
  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    done_d      = done_q;
    k_d         = k_q;
    if (en) begin
      done_d = last;
      case (state_q)
        IDLE: begin
          if (accept) begin
            act_d   = in_act;
            k_d     = '0;
            state_d = STREAM;
          end
        end
        STREAM: begin
          if (k_q == KLAST) begin
            k_d = '0;
            if (hold_full_q) begin
              act_d       = hold_q;
              hold_full_d = 1'b0;
            end else if (accept) begin
              act_d = in_act;
            end else begin
              state_d = IDLE;
            end
          end else begin
            // Shifting the whole register right puts bit k of element i at i*Pa.
            act_d = act_q >> 1;
            k_d   = k_q + KW'(1);
            if (accept) begin
              hold_d      = in_act;
              hold_full_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    plane = '0;
    for (int i = 0; i < M; i++) begin
      plane[i] = busy && act_q[i*Pa];
    end
    plane_msb = last;
    w_en      = busy && en;
    cl_en     = busy && en && (k_q == '0);
    s_en      = busy && en && (k_q != '0);
    vec_done  = done_q && en;
  end

endmodule
